// File: rtl/seq_pattern_tx_pkg.sv
// rtl/seq_pattern_tx_pkg.sv - shared types and constants for the serial pattern transmitter
// Contents: FSM state encoding, reset-time default pattern, clog2 helper.
// Optional feature macro used by the top: SEQ_TX_GAP_EN.
package seq_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10,
      DONE = 2'b11
   } state_t;

   // Pattern sitting in the shift register after reset; never sent unless loaded.
   localparam logic [3:0] PKG_DEFAULT_PAT = 4'b0101;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - load handshake bundle for the serial pattern transmitter
// Signals:
//   load_valid   - request to start a frame (master -> slave)
//   load_ready   - slave can accept a load this cycle (slave -> master)
//   load_pattern - PAT_W-bit pattern, MSB sent first (master -> slave)
//   load_reps    - repetition count, 0 sends nothing (master -> slave)
interface seq_pattern_tx_if #(
   parameter int PAT_W = 4,
   parameter int REP_W = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [PAT_W-1:0] load_pattern;
   logic [REP_W-1:0] load_reps;

   modport master (output load_valid, output load_pattern, output load_reps, input load_ready);
   modport slave  (input load_valid, input load_pattern, input load_reps, output load_ready);
endinterface

// File: rtl/seq_pattern_tx_shreg.sv
// rtl/seq_pattern_tx_shreg.sv - loadable rotate-left pattern register
// Ports:
//   clk, reset - rising-edge clock, synchronous active-high reset (loads INIT)
//   load       - capture din (has priority over shift)
//   shift      - rotate left by one bit
//   din        - parallel load value
//   msb        - current bit PAT_W-1
module seq_tx_shreg #(
   parameter int PAT_W = 4,
   parameter logic [PAT_W-1:0] INIT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] din,
   output logic             msb
);
   logic [PAT_W-1:0] q;

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= INIT;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {q[PAT_W-2:0], q[PAT_W-1]};
      end
   end

   assign msb = q[PAT_W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial bit-pattern transmitter, MSB first, with repeat count
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   load        - slave side of the load handshake (valid/ready/pattern/reps)
//   dout        - registered serial bit, 0 whenever dout_valid is low
//   dout_valid  - registered, high while a pattern bit is on dout
//   busy        - high from the cycle after acceptance until DONE exits
//   done        - one-cycle pulse when the frame completes
// Optional feature macro: SEQ_TX_GAP_EN inserts GAP_LEN idle cycles between repetitions.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int REP_W = 4,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(PKG_DEFAULT_PAT)
`ifdef SEQ_TX_GAP_EN
   ,parameter int GAP_LEN = 2
`endif
) (
   input  logic clk,
   input  logic reset,
   seq_pattern_tx_if.slave load,
   output logic dout,
   output logic dout_valid,
   output logic busy,
   output logic done
);
   localparam int BIT_W = clog2(PAT_W);

   state_t           state, next_state;
   logic [BIT_W-1:0] bit_cnt;
   logic [REP_W-1:0] rep_cnt, reps_q, reps_m1;
   logic             accept, last_bit, last_rep, shift, shreg_msb;
   logic [PAT_W-1:0] shreg_din;

   assign load.load_ready = (state == IDLE);
   assign accept          = load.load_valid && (state == IDLE);
   assign busy            = (state != IDLE);
   assign done            = (state == DONE);

   assign last_bit = (bit_cnt == BIT_W'(PAT_W - 1));
   assign reps_m1  = (reps_q != '0) ? reps_q - REP_W'(1) : '0;
   assign last_rep = (rep_cnt == reps_m1);

`ifdef SEQ_TX_GAP_EN
   localparam int GAP_W = clog2(GAP_LEN + 1);
   logic [GAP_W-1:0] gap_cnt;
   logic             gap_end;

   assign gap_end = (gap_cnt == GAP_W'(GAP_LEN - 1));

   always_ff @(posedge clk) begin
      if (reset || state != GAP) begin
         gap_cnt <= '0;
      end else begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (load.load_valid) next_state = (load.load_reps != '0) ? SEND : DONE;
         SEND: begin
            if (last_bit) begin
               if (last_rep) begin
                  next_state = DONE;
               end else begin
`ifdef SEQ_TX_GAP_EN
                  next_state = GAP;
`else
                  next_state = SEND;
`endif
               end
            end
         end
`ifdef SEQ_TX_GAP_EN
         GAP:  if (gap_end) next_state = SEND;
`endif
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // dout is registered, so the register must already hold the bit for the
   // next cycle. The shift register is therefore kept one bit ahead of dout:
   // it is loaded pre-rotated and only advances while another bit follows.
   // After a full repetition it is back to the pattern, msb = first bit.
   assign shreg_din = {load.load_pattern[PAT_W-2:0], load.load_pattern[PAT_W-1]};
   assign shift     = (next_state == SEND) && (state != IDLE);

   seq_tx_shreg #(.PAT_W(PAT_W), .INIT(DEFAULT_PAT)) u_shreg (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .shift (shift),
      .din   (shreg_din),
      .msb   (shreg_msb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         rep_cnt    <= '0;
         reps_q     <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
      end else begin
         state      <= next_state;
         dout_valid <= (next_state == SEND);
         if (next_state == SEND) begin
            dout <= (state == IDLE) ? load.load_pattern[PAT_W-1] : shreg_msb;
         end else begin
            dout <= 1'b0;
         end
         if (accept) begin
            bit_cnt <= '0;
            rep_cnt <= '0;
            reps_q  <= load.load_reps;
         end else if (state == SEND) begin
            if (last_bit) begin
               bit_cnt <= '0;
               rep_cnt <= rep_cnt + 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;
   localparam int PAT_W = 4;
   localparam int REP_W = 4;
`ifdef SEQ_TX_GAP_EN
   localparam int GAP = 2;
`else
   localparam int GAP = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic dout, dout_valid, busy, done;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W)) lif ();

   seq_pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (lif),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [PAT_W-1:0] pat;
      int               reps;
      bit               inject;
      logic [PAT_W-1:0] inj_pat;
      int               exp_valid;
   } vec_t;

   vec_t vecs[6];

   // Observed vector: {dout_valid, dout, done, busy, load_ready}
   function automatic logic [4:0] obs();
      return {dout_valid, dout, done, busy, lif.load_ready};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [PAT_W-1:0] pat, input int reps, input bit inject,
                            input logic [PAT_W-1:0] inj_pat, input int exp_valid);
      logic [4:0] exp_q[$];
      int nvalid;
      int wait_n;
      nvalid = 0;
      wait_n = 0;
      for (int r = 0; r < reps; r++) begin
         for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({1'b1, pat[i], 3'b010});
         if (r < reps - 1) for (int g = 0; g < GAP; g++) exp_q.push_back(5'b00010);
      end
      exp_q.push_back(5'b00110);

      while (lif.load_ready !== 1'b1 && wait_n < 50) begin
         tick();
         wait_n++;
      end
      if (wait_n >= 50) check("ready_timeout", 32'd0, 32'd1);

      lif.load_valid   = 1'b1;
      lif.load_pattern = pat;
      lif.load_reps    = REP_W'(reps);
      tick();
      if (inject) begin
         lif.load_pattern = inj_pat;
         lif.load_reps    = REP_W'($urandom_range(1, 15));
      end else begin
         lif.load_valid = 1'b0;
      end
      foreach (exp_q[c]) begin
         check($sformatf("frame_p%b_r%0d_cyc%0d", pat, reps, c), 32'(obs()), 32'(exp_q[c]));
         if (dout_valid === 1'b1) nvalid++;
         tick();
      end
      lif.load_valid = 1'b0;
      check("idle_after_done", 32'(obs()), 32'h01);
      check("valid_bit_count", 32'(nvalid), 32'(exp_valid));
   endtask

   initial begin
      reset            = 1'b1;
      lif.load_valid   = 1'b0;
      lif.load_pattern = '0;
      lif.load_reps    = '0;
      tick();
      tick();
      check("reset_state", 32'(obs()), 32'h01);
      reset = 1'b0;
      check("after_release", 32'(obs()), 32'h01);

      vecs[0] = '{pat: 4'b0101, reps: 1,  inject: 1'b0, inj_pat: 4'b0000, exp_valid: 4};
      vecs[1] = '{pat: 4'b0101, reps: 3,  inject: 1'b0, inj_pat: 4'b0000, exp_valid: 12};
      vecs[2] = '{pat: 4'b0101, reps: 0,  inject: 1'b0, inj_pat: 4'b0000, exp_valid: 0};
      vecs[3] = '{pat: 4'b1100, reps: 2,  inject: 1'b1, inj_pat: 4'b0011, exp_valid: 8};
      vecs[4] = '{pat: 4'b1001, reps: 15, inject: 1'b0, inj_pat: 4'b0000, exp_valid: 60};
      vecs[5] = '{pat: 4'b1000, reps: 1,  inject: 1'b1, inj_pat: 4'b0111, exp_valid: 4};

      for (int v = 0; v < 6; v++)
         run_frame(vecs[v].pat, vecs[v].reps, vecs[v].inject, vecs[v].inj_pat, vecs[v].exp_valid);

      for (int n = 0; n < 25; n++) begin
         logic [PAT_W-1:0] p, q;
         int reps;
         p    = PAT_W'($urandom);
         q    = PAT_W'($urandom);
         reps = $urandom_range(0, 6);
         run_frame(p, reps, 1'($urandom_range(0, 1)), q, reps * PAT_W);
      end

      // Reset while the third bit of a 0101 x2 frame is on the wire.
      lif.load_valid   = 1'b1;
      lif.load_pattern = 4'b0101;
      lif.load_reps    = 4'd2;
      tick();
      lif.load_valid = 1'b0;
      check("rst_seq_bit0", 32'(obs()), 32'b10010);
      tick();
      check("rst_seq_bit1", 32'(obs()), 32'b11010);
      tick();
      check("rst_seq_bit2", 32'(obs()), 32'b10010);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_mid_frame", 32'(obs()), 32'h01);
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("no_done_after_reset%0d", i), 32'(obs()), 32'h01);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
